// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
//   DEFAULT_WORD_LEN     : default address/data width
//   DEFAULT_STARVE_LIMIT : default stalled-fetch cycles before fetch is forced
//   owner_e              : which requester owns an outstanding response
package mem_arbiter_pkg;

    localparam int unsigned DEFAULT_WORD_LEN     = 32;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating starvation counter for the fetch requester.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   stall    : fetch is requesting but was not granted this cycle
//   clear    : fetch was granted or is not requesting
//   at_limit : counter has reached LIMIT
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic clear,
    output logic at_limit
);

    localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    assign at_limit = (r_cnt == CW'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (stall && !at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data has fixed priority; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive stalled fetch cycles. Responses are one-cycle
// pulses in the cycle after the grant, aligned with mem_rdata.
//   clk, rst                          : clock, synchronous active-high reset
//   i_req_valid/i_req_ready, i_addr   : fetch request handshake
//   i_rsp_valid, i_rsp_data           : fetch response pulse
//   d_req_valid/d_req_ready, d_addr,
//   d_we, d_wdata, d_wstrb            : data request handshake
//   d_rsp_valid, d_rsp_data           : load data / store ack pulse
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_wstrb, mem_rdata   : memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_LEN     = DEFAULT_WORD_LEN,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [WORD_LEN-1:0]   i_addr,
    output logic                  i_rsp_valid,
    output logic [WORD_LEN-1:0]   i_rsp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [WORD_LEN-1:0]   d_addr,
    input  logic                  d_we,
    input  logic [WORD_LEN-1:0]   d_wdata,
    input  logic [WORD_LEN/8-1:0] d_wstrb,
    output logic                  d_rsp_valid,
    output logic [WORD_LEN-1:0]   d_rsp_data,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [WORD_LEN-1:0]   mem_addr,
    output logic [WORD_LEN-1:0]   mem_wdata,
    output logic [WORD_LEN/8-1:0] mem_wstrb,
    input  logic [WORD_LEN-1:0]   mem_rdata
);

    logic   w_at_limit;
    logic   w_force_i;
    logic   w_grant_i;
    logic   w_grant_d;
    logic   w_stall;
    logic   w_clear;

    logic   r_rsp_pend;
    owner_e r_rsp_owner;
    logic   r_rsp_is_write;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .stall    (w_stall),
        .clear    (w_clear),
        .at_limit (w_at_limit)
    );

    // Grant and memory mux. Grants are gated by rst so nothing reaches the
    // memory while reset is held.
    always_comb begin
        w_force_i = i_req_valid && w_at_limit;
        w_grant_d = !rst && d_req_valid && !w_force_i;
        w_grant_i = !rst && i_req_valid && !w_grant_d;

        i_req_ready = w_grant_i;
        d_req_ready = w_grant_d;

        w_stall = i_req_valid && !w_grant_i;
        w_clear = w_grant_i || !i_req_valid;

        mem_en    = w_grant_i || w_grant_d;
        mem_we    = w_grant_d && d_we;
        mem_addr  = w_grant_d ? d_addr : i_addr;
        mem_wdata = d_wdata;
        mem_wstrb = mem_we ? d_wstrb : '0;
    end

    // Response tracker: remembers this cycle's grant so the pulse lines up
    // with mem_rdata one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_pend     <= 1'b0;
            r_rsp_owner    <= OWNER_I;
            r_rsp_is_write <= 1'b0;
        end else begin
            r_rsp_pend     <= w_grant_i || w_grant_d;
            r_rsp_owner    <= w_grant_d ? OWNER_D : OWNER_I;
            r_rsp_is_write <= w_grant_d && d_we;
        end
    end

    // Gating by rst drops a response that falls due while reset is asserted.
    assign i_rsp_valid = !rst && r_rsp_pend && (r_rsp_owner == OWNER_I);
    assign d_rsp_valid = !rst && r_rsp_pend && (r_rsp_owner == OWNER_D);
    assign i_rsp_data  = mem_rdata;
    assign d_rsp_data  = r_rsp_is_write ? '0 : mem_rdata;

endmodule
